// File: rtl/frame_merge_pkg.sv
// Shared frame markers and arbiter state encoding for frame_merge_arbiter.
// The ABORT state exists only when FRAME_TIMEOUT_EN is defined.
package frame_merge_pkg;

  localparam logic [7:0] HEADER_ID  = 8'hAA;
  localparam logic [7:0] FOOTER_ID  = 8'h55;
  localparam logic [7:0] ABORT_CODE = 8'hEE;

`ifdef FRAME_TIMEOUT_EN
  typedef enum logic [1:0] {StIdle, StXfer, StAbort} state_e;
`else
  typedef enum logic [1:0] {StIdle, StXfer} state_e;
`endif

endpackage

// File: rtl/frame_merge_arbiter_rr_select.sv
// Round-robin picker: first requester after last_i, wrapping modulo N.
module rr_select #(
  parameter int unsigned N  = 4,
  parameter int unsigned GW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [GW-1:0] last_i,
  output logic [GW-1:0] grant_o,
  output logic          found_o
);

  always_comb begin
    grant_o = '0;
    found_o = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      if (!found_o && req_i[(32'(last_i) + i) % N]) begin
        found_o = 1'b1;
        grant_o = GW'((32'(last_i) + i) % N);
      end
    end
  end

endmodule

// File: rtl/frame_merge_arbiter.sv
// Merges N_CH framed word streams onto one output, one whole frame at a time.
// Define FRAME_TIMEOUT_EN to add the mid-frame stall timeout and ABORT footer.
module frame_merge_arbiter
  import frame_merge_pkg::*;
#(
  parameter int unsigned N_CH           = 4,
  parameter int unsigned DOUT_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                       RD_CLK,
  input  logic                       RD_RESET,
  input  logic [N_CH*DOUT_WIDTH-1:0] CH_DIN,
  input  logic [N_CH-1:0]            CH_VALID,
  output logic [N_CH-1:0]            CH_READY,
  output logic [DOUT_WIDTH-1:0]      DOUT,
  output logic                       oVALID,
  input  logic                       iREADY,
  output logic [$clog2(N_CH)-1:0]    GRANT_ID,
  output logic                       BUSY,
  output logic [15:0]                DROP_CNT
);

  localparam int unsigned GW = $clog2(N_CH);

  if (N_CH < 2 || N_CH > 16 || DOUT_WIDTH < 16 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("frame_merge_arbiter: illegal parameter value");
  end

  state_e                state_q, state_d;
  logic [GW-1:0]         grant_q, grant_d;
  logic [DOUT_WIDTH-1:0] dout_q;
  logic                  ovalid_q;
  logic [15:0]           drop_q;

  logic [DOUT_WIDTH-1:0] ch_word [N_CH];
  logic [N_CH-1:0]       hdr_req, dat_req, ch_ready;
  logic [GW-1:0]         rr_grant, drop_idx;
  logic                  rr_found, drop_found;
  logic                  out_free, load, drop_en, footer_acc;
  logic [DOUT_WIDTH-1:0] load_word;

  always_comb begin
    for (int i = 0; i < int'(N_CH); i++) begin
      ch_word[i] = CH_DIN[i*DOUT_WIDTH +: DOUT_WIDTH];
      hdr_req[i] = CH_VALID[i] && (ch_word[i][DOUT_WIDTH-1 -: 8] == HEADER_ID);
      dat_req[i] = CH_VALID[i] && !hdr_req[i];
    end
  end

  rr_select #(
    .N  (N_CH),
    .GW (GW)
  ) u_rr_select (
    .req_i   (hdr_req),
    .last_i  (grant_q),
    .grant_o (rr_grant),
    .found_o (rr_found)
  );

  // Descending scan so the lowest-index stray word wins.
  always_comb begin
    drop_found = 1'b0;
    drop_idx   = '0;
    for (int i = int'(N_CH) - 1; i >= 0; i--) begin
      if (dat_req[i]) begin
        drop_found = 1'b1;
        drop_idx   = GW'(i);
      end
    end
  end

  assign out_free   = ~ovalid_q | iREADY;
  assign footer_acc = (state_q == StXfer) && load &&
                      (ch_word[grant_q][DOUT_WIDTH-1 -: 8] == FOOTER_ID);

`ifdef FRAME_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            timeout;

  // Counts consecutive XFER cycles in which the owner presents nothing.
  always_comb begin
    cnt_d   = '0;
    timeout = 1'b0;
    if (state_q == StXfer && !CH_VALID[grant_q]) begin
      if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
        timeout = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge RD_CLK or posedge RD_RESET) begin
    if (RD_RESET) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
`endif

  // State register
  always_ff @(posedge RD_CLK or posedge RD_RESET) begin
    if (RD_RESET) begin
      state_q <= StIdle;
      grant_q <= GW'(N_CH - 1);
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    unique case (state_q)
      StIdle: begin
        if (rr_found && out_free) begin
          state_d = StXfer;
          grant_d = rr_grant;
        end
      end
      StXfer: begin
        if (footer_acc) begin
          state_d = StIdle;
`ifdef FRAME_TIMEOUT_EN
        end else if (timeout) begin
          state_d = StAbort;
`endif
        end
      end
`ifdef FRAME_TIMEOUT_EN
      StAbort: begin
        if (out_free) begin
          state_d = StIdle;
        end
      end
`endif
      default: state_d = StIdle;
    endcase
  end

  // Output / handshake decode
  always_comb begin
    ch_ready  = '0;
    load      = 1'b0;
    drop_en   = 1'b0;
    load_word = ch_word[grant_q];
    unique case (state_q)
      StIdle: begin
        if (rr_found) begin
          ch_ready[rr_grant] = out_free;
          load               = out_free;
          load_word          = ch_word[rr_grant];
        end else if (drop_found) begin
          ch_ready[drop_idx] = 1'b1;
          drop_en            = 1'b1;
        end
      end
      StXfer: begin
        ch_ready[grant_q] = out_free;
        load              = out_free & CH_VALID[grant_q];
      end
`ifdef FRAME_TIMEOUT_EN
      StAbort: begin
        load      = out_free;
        load_word = {FOOTER_ID, ABORT_CODE, {(DOUT_WIDTH - 16){1'b0}}};
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge RD_CLK or posedge RD_RESET) begin
    if (RD_RESET) begin
      dout_q   <= '0;
      ovalid_q <= 1'b0;
      drop_q   <= '0;
    end else begin
      if (load) begin
        dout_q   <= load_word;
        ovalid_q <= 1'b1;
      end else if (iREADY) begin
        ovalid_q <= 1'b0;
      end
      if (drop_en && drop_q != 16'hFFFF) begin
        drop_q <= drop_q + 16'd1;
      end
    end
  end

  // Ready is combinational from CH_VALID, so hold it off while reset is asserted.
  assign CH_READY = RD_RESET ? '0 : ch_ready;
  assign DOUT     = dout_q;
  assign oVALID   = ovalid_q;
  assign GRANT_ID = grant_q;
  assign BUSY     = (state_q != StIdle);
  assign DROP_CNT = drop_q;

endmodule

// File: tb/tb_frame_merge_arbiter.sv
// Directed self-checking bench for frame_merge_arbiter (4 channels, 64-bit words).
module tb_frame_merge_arbiter;

  localparam int N = 4;
  localparam int W = 64;
  localparam logic [63:0] ABORT_WORD = 64'h55EE_0000_0000_0000;

  typedef logic [63:0] word_t;

  logic           clk;
  logic           rst;
  logic [N*W-1:0] ch_din;
  logic [N-1:0]   ch_valid;
  logic [N-1:0]   ch_ready;
  logic [W-1:0]   dout;
  logic           ovalid;
  logic           iready;
  logic [1:0]     grant_id;
  logic           busy;
  logic [15:0]    drop_cnt;

  word_t chq [N][$];
  word_t rxq [$];
  word_t exp_q [$];
  logic  last_acc;
  word_t last_word;
  int    n_checks;
  int    n_fail;

  frame_merge_arbiter #(
    .N_CH           (N),
    .DOUT_WIDTH     (W),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .RD_CLK   (clk),
    .RD_RESET (rst),
    .CH_DIN   (ch_din),
    .CH_VALID (ch_valid),
    .CH_READY (ch_ready),
    .DOUT     (dout),
    .oVALID   (ovalid),
    .iREADY   (iready),
    .GRANT_ID (grant_id),
    .BUSY     (busy),
    .DROP_CNT (drop_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic word_t hdr(int ch);
    return {8'hAA, 8'(ch), 48'h0};
  endfunction

  function automatic word_t dat(int ch, int k);
    return {8'h11, 8'(ch), 48'(k)};
  endfunction

  function automatic word_t ftr(int ch);
    return {8'h55, 8'(ch), 48'hF};
  endfunction

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (chq[i].size() > 0) begin
        ch_valid[i]        = 1'b1;
        ch_din[i*W +: W]   = chq[i][0];
      end else begin
        ch_valid[i]        = 1'b0;
        ch_din[i*W +: W]   = '0;
      end
    end
  endtask

  // Samples handshakes before the edge, then updates sources and sink after it.
  task automatic cycle();
    logic [N-1:0] fire;
    logic         ofire;
    word_t        ow;
    #2;
    fire  = ch_valid & ch_ready;
    ofire = ovalid & iready;
    ow    = dout;
    @(posedge clk);
    #1;
    last_acc  = |fire;
    last_word = '0;
    for (int i = 0; i < N; i++) begin
      if (fire[i]) begin
        last_word = chq[i][0];
        void'(chq[i].pop_front());
      end
    end
    if (ofire) rxq.push_back(ow);
    drive();
  endtask

  task automatic drain(input int bound, output logic ok);
    int   n;
    logic pending;
    n = 0;
    pending = 1'b1;
    while (pending && n < bound) begin
      cycle();
      n++;
      pending = ovalid | busy;
      for (int i = 0; i < N; i++) if (chq[i].size() > 0) pending = 1'b1;
    end
    ok = !pending;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    iready = 1'b1;
    for (int i = 0; i < N; i++) chq[i].delete();
    drive();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    rxq.delete();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (ovalid !== 1'b0) begin n_fail++; $display("FAIL reset_ovalid got %0b want 0", ovalid); end
    n_checks++; if (dout !== '0) begin n_fail++; $display("FAIL reset_dout got %h want 0", dout); end
    n_checks++; if (ch_ready !== 4'b0) begin n_fail++; $display("FAIL reset_ready got %b want 0000", ch_ready); end
    n_checks++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL reset_grant got %0d want 3", grant_id); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %0b want 0", busy); end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL reset_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_single_frame();
    word_t fr [5];
    do_reset();
    fr = '{hdr(0), dat(0, 1), dat(0, 2), dat(0, 3), ftr(0)};
    for (int k = 0; k < 5; k++) chq[0].push_back(fr[k]);
    drive();
    for (int k = 0; k < 5; k++) begin
      cycle();
      n_checks++; if (last_word !== fr[k]) begin n_fail++; $display("FAIL single_accept[%0d] got %h want %h", k, last_word, fr[k]); end
      n_checks++; if (ovalid !== 1'b1 || dout !== fr[k]) begin n_fail++; $display("FAIL single_dout[%0d] got %b/%h want 1/%h", k, ovalid, dout, fr[k]); end
      n_checks++; if (grant_id !== 2'd0) begin n_fail++; $display("FAIL single_grant[%0d] got %0d want 0", k, grant_id); end
      n_checks++; if (busy !== (k < 4)) begin n_fail++; $display("FAIL single_busy[%0d] got %0b want %0b", k, busy, k < 4); end
    end
    cycle();
    n_checks++; if (rxq.size() != 5) begin n_fail++; $display("FAIL single_count got %0d want 5", rxq.size()); end
  endtask

  task automatic test_all_headers();
    logic ok;
    do_reset();
    exp_q.delete();
    for (int c = 0; c < N; c++) begin
      chq[c].push_back(hdr(c)); chq[c].push_back(dat(c, 7)); chq[c].push_back(ftr(c));
      exp_q.push_back(hdr(c)); exp_q.push_back(dat(c, 7)); exp_q.push_back(ftr(c));
    end
    drive();
    drain(200, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL rr_drain timed out got %0b want 1", ok); end
    n_checks++; if (rxq.size() != 12) begin n_fail++; $display("FAIL rr_count got %0d want 12", rxq.size()); end
    for (int k = 0; k < 12 && k < rxq.size(); k++) begin
      n_checks++; if (rxq[k] !== exp_q[k]) begin n_fail++; $display("FAIL rr_order[%0d] got %h want %h", k, rxq[k], exp_q[k]); end
    end
    n_checks++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL rr_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_backpressure();
    logic ok;
    do_reset();
    exp_q = '{hdr(0), dat(0, 1), dat(0, 2), dat(0, 3), ftr(0)};
    foreach (exp_q[k]) chq[0].push_back(exp_q[k]);
    drive();
    cycle();
    cycle();
    iready = 1'b0;
    repeat (10) begin
      #1;
      n_checks++; if (ch_ready[0] !== 1'b0) begin n_fail++; $display("FAIL bp_ready got %0b want 0", ch_ready[0]); end
      n_checks++; if (ovalid !== 1'b1 || dout !== dat(0, 1)) begin n_fail++; $display("FAIL bp_hold got %b/%h want 1/%h", ovalid, dout, dat(0, 1)); end
      cycle();
    end
    iready = 1'b1;
    drain(100, ok);
    n_checks++; if (ok !== 1'b1) begin n_fail++; $display("FAIL bp_drain timed out got %0b want 1", ok); end
    n_checks++; if (rxq.size() != 5) begin n_fail++; $display("FAIL bp_count got %0d want 5", rxq.size()); end
    for (int k = 0; k < 5 && k < rxq.size(); k++) begin
      n_checks++; if (rxq[k] !== exp_q[k]) begin n_fail++; $display("FAIL bp_order[%0d] got %h want %h", k, rxq[k], exp_q[k]); end
    end
  endtask

  task automatic test_drop();
    do_reset();
    chq[2].push_back(dat(2, 1));
    chq[2].push_back(dat(2, 2));
    drive();
    #1;
    n_checks++; if (ch_ready !== 4'b0100) begin n_fail++; $display("FAIL drop_ready got %b want 0100", ch_ready); end
    repeat (2) begin
      cycle();
      n_checks++; if (ovalid !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL drop_idle got ovalid=%0b busy=%0b want 0/0", ovalid, busy); end
    end
    cycle();
    n_checks++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL drop_cnt got %0d want 2", drop_cnt); end
    n_checks++; if (chq[2].size() != 0) begin n_fail++; $display("FAIL drop_consumed got %0d want 0 left", chq[2].size()); end
    n_checks++; if (rxq.size() != 0) begin n_fail++; $display("FAIL drop_output got %0d want 0 words", rxq.size()); end
  endtask

  task automatic test_reset_mid_frame();
    logic ok;
    do_reset();
    chq[0].push_back(hdr(0)); chq[0].push_back(dat(0, 1));
    chq[0].push_back(dat(0, 2)); chq[0].push_back(ftr(0));
    drive();
    cycle();
    cycle();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL mid_busy got %0b want 1", busy); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (ovalid !== 1'b0 || dout !== '0) begin n_fail++; $display("FAIL mid_out got %b/%h want 0/0", ovalid, dout); end
    n_checks++; if (ch_ready !== 4'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL mid_ctl got ready=%b busy=%0b want 0000/0", ch_ready, busy); end
    n_checks++; if (grant_id !== 2'd3) begin n_fail++; $display("FAIL mid_grant got %0d want 3", grant_id); end
    for (int i = 0; i < N; i++) chq[i].delete();
    drive();
    @(posedge clk);
    #1;
    rst = 1'b0;
    rxq.delete();
    chq[1].push_back(hdr(1)); chq[1].push_back(ftr(1));
    chq[0].push_back(hdr(0)); chq[0].push_back(ftr(0));
    drive();
    cycle();
    n_checks++; if (last_word !== hdr(0) || grant_id !== 2'd0) begin n_fail++; $display("FAIL mid_first got %h/%0d want %h/0", last_word, grant_id, hdr(0)); end
    drain(100, ok);
    n_checks++; if (ok !== 1'b1 || rxq.size() != 4) begin n_fail++; $display("FAIL mid_drain got ok=%0b n=%0d want 1/4", ok, rxq.size()); end
    if (rxq.size() == 4) begin
      n_checks++; if (rxq[2] !== hdr(1)) begin n_fail++; $display("FAIL mid_second got %h want %h", rxq[2], hdr(1)); end
    end
  endtask

`ifdef FRAME_TIMEOUT_EN
  task automatic test_timeout();
    int   n;
    logic found;
    do_reset();
    chq[1].push_back(hdr(1));
    drive();
    cycle();
    n_checks++; if (last_word !== hdr(1)) begin n_fail++; $display("FAIL to_header got %h want %h", last_word, hdr(1)); end
    n = 0;
    found = 1'b0;
    while (!found && n < 40) begin
      cycle();
      n++;
      if (ovalid && dout === ABORT_WORD) found = 1'b1;
    end
    n_checks++; if (found !== 1'b1 || n != 17) begin n_fail++; $display("FAIL to_abort got found=%0b after %0d want 1 after 17", found, n); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL to_idle got busy=%0b want 0", busy); end
  endtask
`endif

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    iready    = 1'b1;
    ch_valid  = '0;
    ch_din    = '0;
    last_acc  = 1'b0;
    last_word = '0;
    test_reset();
    test_single_frame();
    test_all_headers();
    test_backpressure();
    test_drop();
    test_reset_mid_frame();
`ifdef FRAME_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/frame_merge_arbiter.md
FRAME_MERGE_ARBITER -- requirements
Module: frame_merge_arbiter

Interface
REQ-001 Parameter N_CH, default 4, meaning number of trigger-channel frame streams merged (2..16).
REQ-002 Parameter DOUT_WIDTH, default 64, meaning frame word width.
REQ-003 Parameter TIMEOUT_CYCLES, default 1024, meaning mid-frame stall limit in RD_CLK cycles (used only with FRAME_TIMEOUT_EN).
REQ-004 Port RD_CLK, input, 1, meaning the single clock; all logic is in this domain.
REQ-005 Port RD_RESET, input, 1, meaning reset, asynchronous and active-high.
REQ-006 Port CH_DIN, input, N_CH*DOUT_WIDTH, meaning channel i word in slice [i*DOUT_WIDTH +: DOUT_WIDTH].
REQ-007 Port CH_VALID, input, N_CH, meaning per-channel word valid.
REQ-008 Port CH_READY, output, N_CH, meaning per-channel word accepted when paired with CH_VALID.
REQ-009 Port DOUT, output, DOUT_WIDTH, meaning merged frame word.
REQ-010 Port oVALID, output, 1, meaning DOUT valid.
REQ-011 Port iREADY, input, 1, meaning downstream accepts DOUT when paired with oVALID.
REQ-012 Port GRANT_ID, output, clog2(N_CH), meaning index of the channel currently owning the output.
REQ-013 Port BUSY, output, 1, meaning a frame is in progress (state not IDLE).
REQ-014 Port DROP_CNT, output, 16, meaning count of discarded out-of-frame words, saturating at 16'hFFFF.

Function
REQ-015 Header word SHALL be identified by DIN[63:56]==8'hAA and footer word by DIN[63:56]==8'h55.
REQ-016 FSM states SHALL be IDLE, XFER, ABORT.
REQ-017 In IDLE the arbiter SHALL round-robin search from (last grant+1) mod N_CH for the first channel presenting CH_VALID with a header word, latch GRANT_ID, and enter XFER in the same cycle it accepts that header.
REQ-018 In IDLE a channel presenting a non-header valid word with no header selected that cycle SHALL have the word accepted and discarded; DROP_CNT increments by 1 per discarded word (lowest index drops first, one per cycle).
REQ-019 In XFER only CH_READY[GRANT_ID] SHALL be asserted, equal to (~oVALID | iREADY); all other CH_READY bits are 0.
REQ-020 Output stage SHALL be one register: an accepted word appears on DOUT/oVALID the next cycle; oVALID and DOUT hold while iREADY is low.
REQ-021 Acceptance of a footer word in XFER SHALL return the FSM to IDLE; the next header may be accepted on the following cycle (1 idle cycle between frames).
REQ-022 A header word received in XFER SHALL be passed through unmodified (no frame nesting check).
REQ-023 Simultaneous headers SHALL be granted strictly in round-robin order; no channel waits more than N_CH-1 frames.
REQ-024 ABORT SHALL drive one word {8'h55, 8'hEE, (DOUT_WIDTH-16) zeros} into the output register when it is free, then return to IDLE.

Reset
REQ-025 While RD_RESET is high: state=IDLE, oVALID=0, DOUT=0, CH_READY=0, GRANT_ID=N_CH-1 (so channel 0 is searched first), BUSY=0, DROP_CNT=0, timeout counter=0.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no footer emitted.

Configuration
REQ-027 With FRAME_TIMEOUT_EN defined, a counter SHALL count consecutive XFER cycles with CH_VALID[GRANT_ID]=0; on reaching TIMEOUT_CYCLES the FSM enters ABORT; the counter clears on any accepted word or on leaving XFER.
REQ-028 Without FRAME_TIMEOUT_EN, no counter or ABORT state SHALL be built and XFER waits indefinitely for a footer.

Structure
REQ-029 HEADER_ID (8'hAA), FOOTER_ID (8'h55), ABORT_CODE (8'hEE) and the state enum SHALL reside in shared package frame_merge_pkg.
REQ-030 Round-robin selection SHALL be a sub-module rr_select (request vector, last grant in; grant index and found flag out).

Verification
REQ-031 Channel 0 sends header, 3 data words, footer, with iREADY=1 -> 5 words on DOUT in order, each 1 cycle after acceptance, GRANT_ID=0, BUSY low after footer.
REQ-032 All 4 channels present headers at once after reset -> frames output in order ch0, ch1, ch2, ch3, with no interleaving of words.
REQ-033 iREADY held low for 10 cycles mid-frame -> DOUT/oVALID stable, CH_READY[grant]=0, no word lost or duplicated.
REQ-034 Channel 2 sends 2 data words with no preceding header while IDLE -> both discarded, DROP_CNT=2, oVALID stays 0.
REQ-035 FRAME_TIMEOUT_EN, TIMEOUT_CYCLES=16, channel 1 stalls after header -> after 16 cycles one word 0x55EE000000000000 is output and FSM returns to IDLE.
REQ-036 RD_RESET pulsed during XFER -> all outputs at reset values asynchronously; next header from channel 0 is accepted first.
